// File: rtl/ex_stage_if.sv
// EX-stage bus: ID/EX operands and controls plus forward sources in,
// EX/MEM results, stall request and HI/LO contents out.
interface ex_stage_if;
   logic [31:0] regReadData1EX;
   logic [31:0] regReadData2EX;
   logic [31:0] signExtendEX;
   logic [4:0]  registerRtEX;
   logic [4:0]  registerRdEX;
   logic [1:0]  aluOpEX;
   logic        regDstEX;
   logic        aluSrcEX;
   logic [1:0]  forwardA;
   logic [1:0]  forwardB;
   logic [31:0] aluResultMEM;
   logic [31:0] writeDataWB;
   logic [31:0] aluResultEX;
   logic [31:0] writeDataEX;
   logic [4:0]  writeRegEX;
   logic        zeroEX;
   logic        mulBusy;
   logic [31:0] hiEX;
   logic [31:0] loEX;

   modport master (
      output regReadData1EX, regReadData2EX, signExtendEX, registerRtEX,
             registerRdEX, aluOpEX, regDstEX, aluSrcEX, forwardA, forwardB,
             aluResultMEM, writeDataWB,
      input  aluResultEX, writeDataEX, writeRegEX, zeroEX, mulBusy, hiEX, loEX
   );

   modport slave (
      input  regReadData1EX, regReadData2EX, signExtendEX, registerRtEX,
             registerRdEX, aluOpEX, regDstEX, aluSrcEX, forwardA, forwardB,
             aluResultMEM, writeDataWB,
      output aluResultEX, writeDataEX, writeRegEX, zeroEX, mulBusy, hiEX, loEX
   );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding muxes, ALU with funct decode, and a
// 32-cycle shift-add signed multiplier feeding HI/LO that stalls while busy.
module ex_stage (
   input logic       clk,
   input logic       reset_n,
   ex_stage_if.slave bus
);

   typedef enum logic {IDLE, BUSY} mul_state_e;

   mul_state_e  state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [63:0] acc_q, acc_d;
   logic [63:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic        sign_q, sign_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [31:0] op_a;
   logic [31:0] fwd_b;
   logic [31:0] op_b;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] alu_res;
   logic [63:0] acc_step;
   logic [5:0]  funct;
   logic        is_mult;
   logic        mul_start;
   logic        mul_done;
   logic        busy;

   assign funct   = bus.signExtendEX[5:0];
   assign is_mult = (bus.aluOpEX == 2'b10) && (funct == 6'b011000);

   always_comb begin
      unique case (bus.forwardA)
         2'b10:   op_a = bus.aluResultMEM;
         2'b01:   op_a = bus.writeDataWB;
         default: op_a = bus.regReadData1EX;
      endcase
   end

   always_comb begin
      unique case (bus.forwardB)
         2'b10:   fwd_b = bus.aluResultMEM;
         2'b01:   fwd_b = bus.writeDataWB;
         default: fwd_b = bus.regReadData2EX;
      endcase
   end

   assign op_b = bus.aluSrcEX ? bus.signExtendEX : fwd_b;

   always_comb begin
      alu_res = '0;
      unique case (bus.aluOpEX)
         2'b00: alu_res = op_a + op_b;
         2'b01: alu_res = op_a - op_b;
         2'b11: alu_res = op_a | op_b;
         2'b10: begin
            unique case (funct)
               6'b100000: alu_res = op_a + op_b;
               6'b100010: alu_res = op_a - op_b;
               6'b100100: alu_res = op_a & op_b;
               6'b100101: alu_res = op_a | op_b;
               6'b101010: alu_res = {31'b0, ($signed(op_a) < $signed(op_b))};
               6'b010000: alu_res = hi_q;
               6'b010010: alu_res = lo_q;
               default:   alu_res = '0;
            endcase
         end
         default: alu_res = '0;
      endcase
   end

   // Multiplier FSM: state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (is_mult) state_d = BUSY;
         BUSY: if (count_q == 5'd31) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Start is only possible from IDLE, so a mult held in EX never retriggers.
   always_comb begin
      mul_start = 1'b0;
      mul_done  = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE: begin
            mul_start = is_mult;
            busy      = is_mult;
         end
         BUSY: begin
            busy     = (count_q != 5'd31);
            mul_done = (count_q == 5'd31);
         end
         default: busy = 1'b0;
      endcase
   end

   // Magnitudes: -2^31 negates to itself, which reads correctly as unsigned.
   assign abs_a    = op_a[31] ? (~op_a + 32'd1) : op_a;
   assign abs_b    = op_b[31] ? (~op_b + 32'd1) : op_b;
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : 64'd0);

   always_comb begin
      count_d  = count_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      sign_d   = sign_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      if (mul_start) begin
         mcand_d  = {32'b0, abs_a};
         mplier_d = abs_b;
         sign_d   = op_a[31] ^ op_b[31];
         acc_d    = '0;
         count_d  = '0;
      end else if (state_q == BUSY) begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         count_d  = count_q + 5'd1;
         if (mul_done) begin
            {hi_d, lo_d} = sign_q ? (~acc_step + 64'd1) : acc_step;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q  <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         sign_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         count_q  <= count_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         sign_q   <= sign_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign bus.aluResultEX = alu_res;
   assign bus.writeDataEX = fwd_b;
   assign bus.writeRegEX  = bus.regDstEX ? bus.registerRdEX : bus.registerRtEX;
   assign bus.zeroEX      = (alu_res == '0);
   assign bus.mulBusy     = busy;
   assign bus.hiEX        = hi_q;
   assign bus.loEX        = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes model expectations per cycle,
// a negedge monitor pops and compares every DUT output.
module tb_ex_stage;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   ex_stage_if bus ();

   ex_stage dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [31:0] rd1, rd2, imm, mem, wb;
      logic [4:0]  rt, rd;
      logic [1:0]  op, fa, fb;
      logic        regdst, alusrc;
   } stim_t;

   typedef struct {
      string       name;
      logic [31:0] alu, wd, hi, lo;
      logic [4:0]  wr;
      logic        zero, busy;
   } exp_t;

   exp_t        sb[$];
   exp_t        mexp;
   int          total = 0;
   int          bad = 0;
   stim_t       cur;
   int          m_rem = 0;
   logic [63:0] m_prod = '0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   function automatic logic [31:0] pick(logic [1:0] s, logic [31:0] r, logic [31:0] m, logic [31:0] w);
      if (s == 2'b10) return m;
      if (s == 2'b01) return w;
      return r;
   endfunction

   function automatic logic [31:0] val_a(stim_t s);
      return pick(s.fa, s.rd1, s.mem, s.wb);
   endfunction

   function automatic logic [31:0] val_fb(stim_t s);
      return pick(s.fb, s.rd2, s.mem, s.wb);
   endfunction

   function automatic logic [31:0] val_b(stim_t s);
      return s.alusrc ? s.imm : val_fb(s);
   endfunction

   function automatic bit is_mult(stim_t s);
      return (s.op == 2'b10) && (s.imm[5:0] == 6'h18);
   endfunction

   function automatic logic [31:0] alu_model(stim_t s);
      logic [31:0] a, b;
      a = val_a(s);
      b = val_b(s);
      case (s.op)
         2'd0: return a + b;
         2'd1: return a - b;
         2'd3: return a | b;
         default: begin
            case (s.imm[5:0])
               6'h20: return a + b;
               6'h22: return a - b;
               6'h24: return a & b;
               6'h25: return a | b;
               6'h2a: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               6'h10: return m_hi;
               6'h12: return m_lo;
               default: return 32'd0;
            endcase
         end
      endcase
   endfunction

   // Reference multiplier: 32 busy cycles after the start cycle, then HI/LO take the product.
   task automatic tick();
      longint sa, sbv;
      if (m_rem == 0) begin
         if (is_mult(cur)) begin
            sa     = longint'($signed(val_a(cur)));
            sbv    = longint'($signed(val_b(cur)));
            m_prod = 64'(sa * sbv);
            m_rem  = 32;
         end
      end else begin
         m_rem--;
         if (m_rem == 0) begin
            m_hi = m_prod[63:32];
            m_lo = m_prod[31:0];
         end
      end
   endtask

   task automatic apply(stim_t s);
      bus.regReadData1EX = s.rd1;
      bus.regReadData2EX = s.rd2;
      bus.signExtendEX   = s.imm;
      bus.registerRtEX   = s.rt;
      bus.registerRdEX   = s.rd;
      bus.aluOpEX        = s.op;
      bus.regDstEX       = s.regdst;
      bus.aluSrcEX       = s.alusrc;
      bus.forwardA       = s.fa;
      bus.forwardB       = s.fb;
      bus.aluResultMEM   = s.mem;
      bus.writeDataWB    = s.wb;
   endtask

   task automatic push_exp(string nm);
      exp_t e;
      e.name = nm;
      e.alu  = alu_model(cur);
      e.wd   = val_fb(cur);
      e.wr   = cur.regdst ? cur.rd : cur.rt;
      e.zero = (e.alu == 32'd0);
      e.busy = (m_rem == 0) ? is_mult(cur) : (m_rem > 1);
      e.hi   = m_hi;
      e.lo   = m_lo;
      sb.push_back(e);
   endtask

   task automatic drive(stim_t s, string nm, bit do_rst);
      @(posedge clk);
      if (reset_n) tick();
      #1;
      apply(s);
      cur = s;
      if (do_rst) begin
         reset_n = 1'b0;
         m_rem   = 0;
         m_hi    = '0;
         m_lo    = '0;
      end
      push_exp(nm);
      if (do_rst) begin
         #6 reset_n = 1'b1;
      end
   endtask

   function automatic stim_t mk(logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm, logic [1:0] op,
                                logic [1:0] fa, logic [1:0] fb, logic alusrc, logic [31:0] mem,
                                logic [31:0] wb, logic regdst);
      stim_t s;
      s.rd1 = rd1; s.rd2 = rd2; s.imm = imm; s.op = op;
      s.fa = fa; s.fb = fb; s.alusrc = alusrc; s.mem = mem; s.wb = wb;
      s.rt = 5'd3; s.rd = 5'd17; s.regdst = regdst;
      return s;
   endfunction

   function automatic logic [31:0] rval();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         4: return 32'd0 - 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   function automatic stim_t rnd();
      stim_t s;
      logic [5:0] f;
      s.rd1 = rval(); s.rd2 = rval(); s.mem = rval(); s.wb = rval();
      s.imm = rval();
      s.rt = 5'($urandom); s.rd = 5'($urandom);
      s.op = 2'($urandom); s.fa = 2'($urandom); s.fb = 2'($urandom);
      s.regdst = 1'($urandom); s.alusrc = 1'($urandom);
      if (s.op == 2'b10) begin
         case ($urandom_range(0, 9))
            0: f = 6'h20;
            1: f = 6'h22;
            2: f = 6'h24;
            3: f = 6'h25;
            4: f = 6'h2a;
            5: f = 6'h10;
            6: f = 6'h12;
            7: f = 6'h18;
            8: f = 6'h3f;
            default: f = 6'($urandom);
         endcase
         s.imm[5:0] = f;
         if (f == 6'h18) s.alusrc = 1'b0;
      end
      return s;
   endfunction

   task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s.%s got=%h want=%h at %0t", nm, fld, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mexp = sb.pop_front();
         chk(mexp.name, "alu",  bus.aluResultEX, mexp.alu);
         chk(mexp.name, "wdata", bus.writeDataEX, mexp.wd);
         chk(mexp.name, "wreg", {27'b0, bus.writeRegEX}, {27'b0, mexp.wr});
         chk(mexp.name, "zero", {31'b0, bus.zeroEX}, {31'b0, mexp.zero});
         chk(mexp.name, "busy", {31'b0, bus.mulBusy}, {31'b0, mexp.busy});
         chk(mexp.name, "hi", bus.hiEX, mexp.hi);
         chk(mexp.name, "lo", bus.loEX, mexp.lo);
      end
   end

   initial begin
      stim_t nop, s;
      nop = mk(32'd1, 32'd2, 32'd0, 2'b00, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0);
      cur = nop;
      apply(nop);

      drive(nop, "reset", 1'b0);
      drive(nop, "reset", 1'b0);
      #6 reset_n = 1'b1;

      drive(mk(32'd5, 32'd3, 32'd0, 2'b00, 2'b10, 2'b00, 1'b0, 32'd7, 32'd0, 1'b1), "fwdA_mem", 1'b0);
      drive(mk(32'd5, 32'd3, 32'd0, 2'b00, 2'b11, 2'b00, 1'b0, 32'd7, 32'd0, 1'b0), "fwdA_11", 1'b0);
      drive(mk(32'd5, 32'd3, 32'd0, 2'b01, 2'b00, 2'b01, 1'b0, 32'd7, 32'd9, 1'b0), "fwdB_wb", 1'b0);
      drive(mk(32'hFFFF_FFFF, 32'd1, 32'h2a, 2'b10, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1), "slt", 1'b0);
      drive(mk(32'hFFFF_FFFF, 32'd1, 32'h22, 2'b10, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1), "sub", 1'b0);
      drive(mk(32'hFFFF_FFFF, 32'd1, 32'h3f, 2'b10, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1), "badfunct", 1'b0);
      drive(mk(32'h0000_F0F0, 32'd0, 32'h0F00_0F0F, 2'b11, 2'b00, 2'b00, 1'b1, 32'd0, 32'd0, 1'b0), "ori", 1'b0);

      s = mk(32'hFFFF_FFFD, 32'd7, 32'h18, 2'b10, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1);
      repeat (33) drive(s, "mult_m3x7", 1'b0);
      drive(mk(32'd0, 32'd0, 32'h10, 2'b10, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1), "mfhi", 1'b0);
      drive(mk(32'd0, 32'd0, 32'h12, 2'b10, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1), "mflo", 1'b0);

      s = mk(32'h8000_0000, 32'd0, 32'h18, 2'b10, 2'b00, 2'b10, 1'b0, 32'h8000_0000, 32'd0, 1'b1);
      repeat (33) drive(s, "mult_min", 1'b0);
      s = mk(32'd2, 32'd3, 32'h18, 2'b10, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1);
      repeat (33) drive(s, "mult_2x3", 1'b0);
      drive(mk(32'd0, 32'd0, 32'h12, 2'b10, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1), "mflo6", 1'b0);

      s = mk(32'd5, 32'hFFFF_FFFA, 32'h18, 2'b10, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1);
      drive(s, "mult_rst", 1'b0);
      for (int i = 0; i < 40 && m_rem != 18; i++) drive(s, "mult_rst", 1'b0);
      drive(nop, "rst_busy", 1'b1);
      repeat (3) drive(nop, "post_rst", 1'b0);

      for (int i = 0; i < 1500; i++) drive(rnd(), "rand", 1'b0);

      @(negedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
